// File: rtl/baseball_pkg.sv
// Shared types, character codes and message constants for the number-baseball mode.
package baseball_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INPUT_ANSWER,
    ST_ANSWER_CHECK,
    ST_INPUT_GUESS,
    ST_GUESS_ERR,
    ST_SHOW_RESULT,
    ST_WIN,
    ST_LOSE
  } state_e;

  localparam int MAX_DIGITS = 8;

  localparam logic [4:0] C_0      = 5'd0;
  localparam logic [4:0] C_S      = 5'd5;
  localparam logic [4:0] C_g      = 5'd9;
  localparam logic [4:0] C_HYPHEN = 5'd10;
  localparam logic [4:0] C_E      = 5'd11;
  localparam logic [4:0] C_r      = 5'd12;
  localparam logic [4:0] C_L      = 5'd13;
  localparam logic [4:0] C_o      = 5'd17;
  localparam logic [4:0] C_b      = 5'd18;
  localparam logic [4:0] C_d      = 5'd19;
  localparam logic [4:0] C_BLANK  = 5'd31;

  localparam logic [19:0] MSG_ERR  = {C_HYPHEN, C_E, C_r, C_r};
  localparam logic [19:0] MSG_GOGO = {C_g, C_o, C_g, C_o};
  localparam logic [19:0] MSG_GOOD = {C_g, C_o, C_o, C_d};
  localparam logic [19:0] MSG_LOSE = {C_L, C_o, C_S, C_E};

  // True when any two of the lowest n digits are equal.
  function automatic logic has_dup(input logic [MAX_DIGITS-1:0][3:0] v, input int n);
    logic d;
    d = 1'b0;
    for (int i = 0; i < MAX_DIGITS; i++)
      for (int j = 0; j < MAX_DIGITS; j++)
        if (i < j && j < n && v[i] == v[j]) d = 1'b1;
    return d;
  endfunction

endpackage

// File: rtl/baseball_scorer.sv
// Combinational strike/ball scoring of a guess against the answer.
module baseball_scorer import baseball_pkg::*; #(
  parameter  int NUM_DIGITS = 4,
  localparam int SW         = $clog2(NUM_DIGITS + 1)
) (
  input  logic [NUM_DIGITS-1:0][3:0] guess,
  input  logic [NUM_DIGITS-1:0][3:0] answer,
  output logic [SW-1:0]              strike,
  output logic [SW-1:0]              ball,
  output logic                       dup_guess,
  output logic                       exact
);

  logic [MAX_DIGITS-1:0][3:0] guess_ext;

  always_comb begin
    strike = '0;
    ball   = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      for (int j = 0; j < NUM_DIGITS; j++)
        if (guess[i] == answer[j]) begin
          if (i == j) strike = strike + SW'(1);
          else        ball   = ball + SW'(1);
        end
    guess_ext = '0;
    guess_ext[NUM_DIGITS-1:0] = guess;
    dup_guess = has_dup(guess_ext, NUM_DIGITS);
  end

  assign exact = (strike == SW'(NUM_DIGITS));

endmodule

// File: rtl/number_baseball_core.sv
// Number-baseball game engine: secret entry, guessing, scoring and display.
// Define BASEBALL_ANSWER_MASK_EN to hide non-cursor answer digits during entry.
module number_baseball_core import baseball_pkg::*; #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_MAX    = 9,
  parameter int MAX_ATTEMPTS = 16,
  parameter int BLINK_DIV    = 50_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    active,
  input  logic                    btn_up,
  input  logic                    btn_down,
  input  logic                    btn_left,
  input  logic                    btn_right,
  input  logic                    btn_confirm,
  output logic [MAX_ATTEMPTS-1:0] led,
  output logic [5*NUM_DIGITS-1:0] seg_data,
  output logic [4:0]              attempts,
  output logic                    win,
  output logic                    lose
);

  localparam int SW = $clog2(NUM_DIGITS + 1);
  localparam int CW = $clog2(NUM_DIGITS);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef logic [NUM_DIGITS-1:0][3:0] digits_t;
  typedef logic [NUM_DIGITS-1:0][4:0] seg_t;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cursor_q, cursor_d;
  digits_t                 answer_q, answer_d, guess_q, guess_d;
  logic [4:0]              attempts_q, attempts_d;
  logic [MAX_ATTEMPTS-1:0] led_q, led_d;
  logic [SW-1:0]           strike_q, strike_d, ball_q, ball_d;
  seg_t                    seg_q, seg_d;
  logic                    win_q, win_d, lose_q, lose_d;
  logic [4:0]              btn_prev_q, btn_prev_d;
  logic [BW-1:0]           blink_cnt_q, blink_cnt_d;
  logic                    blink_q, blink_d;

  // Button edges in priority order: confirm, up, down, left, right.
  logic [4:0] btn_now, btn_edge;
  logic       do_confirm, do_up, do_down, do_left, do_right, lr_ok;

  assign btn_now    = {btn_confirm, btn_up, btn_down, btn_left, btn_right};
  assign btn_edge   = btn_now & ~btn_prev_q;
  assign btn_prev_d = btn_now;
  assign do_confirm = btn_edge[4];
  assign do_up      = ~btn_edge[4] & btn_edge[3];
  assign do_down    = ~|btn_edge[4:3] & btn_edge[2];
  assign lr_ok      = ~|btn_edge[4:2];
  assign do_left    = lr_ok & btn_edge[1] & ~btn_edge[0];
  assign do_right   = lr_ok & btn_edge[0] & ~btn_edge[1];

  logic [SW-1:0] g_strike, g_ball;
  logic          g_dup, g_exact, ans_dup;
  logic [MAX_DIGITS-1:0][3:0] ans_ext;

  baseball_scorer #(.NUM_DIGITS(NUM_DIGITS)) u_scorer (
    .guess     (guess_q),
    .answer    (answer_q),
    .strike    (g_strike),
    .ball      (g_ball),
    .dup_guess (g_dup),
    .exact     (g_exact)
  );

  always_comb begin
    ans_ext = '0;
    ans_ext[NUM_DIGITS-1:0] = answer_q;
    ans_dup = has_dup(ans_ext, NUM_DIGITS);
  end

  // Digit/cursor edit applied to whichever vector is being entered.
  digits_t       src_vec, edit_vec;
  logic [3:0]    cur_dig;
  logic [CW-1:0] cursor_mv;

  always_comb begin
    src_vec  = (state_q == ST_INPUT_GUESS) ? guess_q : answer_q;
    edit_vec = src_vec;
    cur_dig  = src_vec[cursor_q];
    if (do_up)
      edit_vec[cursor_q] = (cur_dig == 4'(DIGIT_MAX)) ? 4'd0 : cur_dig + 4'd1;
    else if (do_down)
      edit_vec[cursor_q] = (cur_dig == 4'd0) ? 4'(DIGIT_MAX) : cur_dig - 4'd1;
    cursor_mv = cursor_q;
    if (do_right)
      cursor_mv = (cursor_q == CW'(NUM_DIGITS - 1)) ? '0 : cursor_q + CW'(1);
    else if (do_left)
      cursor_mv = (cursor_q == '0) ? CW'(NUM_DIGITS - 1) : cursor_q - CW'(1);
  end

  always_comb begin
    state_d    = state_q;
    cursor_d   = cursor_q;
    answer_d   = answer_q;
    guess_d    = guess_q;
    attempts_d = attempts_q;
    led_d      = led_q;
    strike_d   = strike_q;
    ball_d     = ball_q;
    case (state_q)
      ST_IDLE: begin
        state_d  = ST_INPUT_ANSWER;
        cursor_d = '0;
      end
      ST_INPUT_ANSWER: begin
        if (do_confirm) state_d = ST_ANSWER_CHECK;
        else begin
          answer_d = edit_vec;
          cursor_d = cursor_mv;
        end
      end
      ST_ANSWER_CHECK: begin
        if (do_confirm) begin
          state_d  = ans_dup ? ST_INPUT_ANSWER : ST_INPUT_GUESS;
          cursor_d = '0;
        end
      end
      ST_INPUT_GUESS: begin
        if (do_confirm) begin
          if (g_dup) state_d = ST_GUESS_ERR;
          else begin
            strike_d   = g_strike;
            ball_d     = g_ball;
            attempts_d = attempts_q + 5'd1;
            for (int i = 0; i < MAX_ATTEMPTS; i++)
              if (attempts_q == 5'(i)) led_d[i] = 1'b1;
            if (g_exact)                                  state_d = ST_WIN;
            else if (attempts_q + 5'd1 == 5'(MAX_ATTEMPTS)) state_d = ST_LOSE;
            else                                          state_d = ST_SHOW_RESULT;
          end
        end else begin
          guess_d  = edit_vec;
          cursor_d = cursor_mv;
        end
      end
      ST_GUESS_ERR, ST_SHOW_RESULT: begin
        if (do_confirm) begin
          state_d  = ST_INPUT_GUESS;
          cursor_d = '0;
        end
      end
      ST_WIN, ST_LOSE: begin
        if (do_confirm) begin
          state_d    = ST_IDLE;
          cursor_d   = '0;
          answer_d   = '0;
          guess_d    = '0;
          attempts_d = '0;
          led_d      = '0;
          strike_d   = '0;
          ball_d     = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Leaving the mode drops all game state, overriding any button.
    if (!active) begin
      state_d    = ST_IDLE;
      cursor_d   = '0;
      answer_d   = '0;
      guess_d    = '0;
      attempts_d = '0;
      led_d      = '0;
      strike_d   = '0;
      ball_d     = '0;
    end
  end

  function automatic seg_t msg4(input logic [19:0] m);
    seg_t r;
    r      = {NUM_DIGITS{C_BLANK}};
    r[3:0] = m;
    return r;
  endfunction

  always_comb begin
    seg_d = '0;
    case (state_q)
      ST_INPUT_ANSWER, ST_INPUT_GUESS: begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          seg_d[i] = {1'b0, src_vec[i]};
`ifdef BASEBALL_ANSWER_MASK_EN
          if (state_q == ST_INPUT_ANSWER && CW'(i) != cursor_q) seg_d[i] = C_HYPHEN;
`endif
          if (CW'(i) == cursor_q && blink_q) seg_d[i] = C_BLANK;
        end
      end
      ST_ANSWER_CHECK: seg_d = msg4(ans_dup ? MSG_ERR : MSG_GOGO);
      ST_GUESS_ERR:    seg_d = msg4(MSG_ERR);
      ST_SHOW_RESULT:  seg_d = msg4({5'(strike_q), C_S, 5'(ball_q), C_b});
      ST_WIN:          seg_d = msg4(MSG_GOOD);
      ST_LOSE:         seg_d = msg4(MSG_LOSE);
      default:         seg_d = '0;
    endcase
    if (!active) seg_d = '0;
  end

  assign win_d  = active & (state_q == ST_WIN);
  assign lose_d = active & (state_q == ST_LOSE);

  // Blink runs regardless of mode so the phase is not tied to game activity.
  always_comb begin
    blink_cnt_d = blink_cnt_q + BW'(1);
    blink_d     = blink_q;
    if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cursor_q    <= '0;
      answer_q    <= '0;
      guess_q     <= '0;
      attempts_q  <= '0;
      led_q       <= '0;
      strike_q    <= '0;
      ball_q      <= '0;
      seg_q       <= '0;
      win_q       <= 1'b0;
      lose_q      <= 1'b0;
      btn_prev_q  <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cursor_q    <= cursor_d;
      answer_q    <= answer_d;
      guess_q     <= guess_d;
      attempts_q  <= attempts_d;
      led_q       <= led_d;
      strike_q    <= strike_d;
      ball_q      <= ball_d;
      seg_q       <= seg_d;
      win_q       <= win_d;
      lose_q      <= lose_d;
      btn_prev_q  <= btn_prev_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end

  assign led      = led_q;
  assign seg_data = seg_q;
  assign attempts = attempts_q;
  assign win      = win_q;
  assign lose     = lose_q;

endmodule

// File: tb/tb_number_baseball_core.sv
// Directed bench for number_baseball_core: default, 2-attempt and 6-digit instances.
module tb_number_baseball_core;
  import baseball_pkg::*;

  localparam logic [4:0] B_C = 5'b10000, B_U = 5'b01000, B_D = 5'b00100,
                         B_L = 5'b00010, B_R = 5'b00001;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] act;
  logic [4:0] btn [3];

  logic [19:0] seg0, seg1;
  logic [29:0] seg2;
  logic [15:0] led0, led2;
  logic [1:0]  led1;
  logic [4:0]  att0, att1, att2;
  logic        win0, win1, win2, lose0, lose1, lose2;

  always #5 clk = ~clk;

  number_baseball_core u0 (
    .clk(clk), .reset(reset), .active(act[0]),
    .btn_up(btn[0][3]), .btn_down(btn[0][2]), .btn_left(btn[0][1]),
    .btn_right(btn[0][0]), .btn_confirm(btn[0][4]),
    .led(led0), .seg_data(seg0), .attempts(att0), .win(win0), .lose(lose0));

  number_baseball_core #(.MAX_ATTEMPTS(2)) u1 (
    .clk(clk), .reset(reset), .active(act[1]),
    .btn_up(btn[1][3]), .btn_down(btn[1][2]), .btn_left(btn[1][1]),
    .btn_right(btn[1][0]), .btn_confirm(btn[1][4]),
    .led(led1), .seg_data(seg1), .attempts(att1), .win(win1), .lose(lose1));

  number_baseball_core #(.NUM_DIGITS(6)) u2 (
    .clk(clk), .reset(reset), .active(act[2]),
    .btn_up(btn[2][3]), .btn_down(btn[2][2]), .btn_left(btn[2][1]),
    .btn_right(btn[2][0]), .btn_confirm(btn[2][4]),
    .led(led2), .seg_data(seg2), .attempts(att2), .win(win2), .lose(lose2));

  typedef struct {
    int          k;
    bit          ent;
    logic [31:0] cur, tgt;
    logic [4:0]  mask;
    logic [39:0] seg;
    logic [4:0]  att;
    logic [15:0] led;
    logic        w, l;
  } step_t;

  step_t steps[$];
  int checks = 0, errors = 0;

  function automatic logic [39:0] m4(int nd, logic [4:0] a, logic [4:0] b, logic [4:0] c, logic [4:0] d);
    logic [39:0] r;
    r = '0;
    for (int i = 0; i < nd; i++) r[i*5 +: 5] = C_BLANK;
    r[19:0] = {a, b, c, d};
    return r;
  endfunction

  function automatic logic [39:0] digs(int nd, logic [31:0] v);
    logic [39:0] r;
    r = '0;
    for (int i = 0; i < nd; i++) r[i*5 +: 5] = {1'b0, v[i*4 +: 4]};
    return r;
  endfunction

  task automatic add(int k, bit ent, logic [31:0] cur, logic [31:0] tgt, logic [4:0] mask,
                     logic [39:0] seg, logic [4:0] att, logic [15:0] led, logic w, logic l);
    step_t s;
    s.k = k; s.ent = ent; s.cur = cur; s.tgt = tgt; s.mask = mask;
    s.seg = seg; s.att = att; s.led = led; s.w = w; s.l = l;
    steps.push_back(s);
  endtask

  // Caller is at a negedge; returns at the negedge after the display update.
  task automatic press(int k, logic [4:0] m);
    btn[k] = m;
    @(negedge clk);
    btn[k] = 5'b0;
    @(negedge clk);
  endtask

  task automatic enter(int k, int nd, logic [31:0] cur, logic [31:0] tgt);
    for (int p = 0; p < nd; p++) begin
      int ups;
      ups = (int'(tgt[p*4 +: 4]) + 10 - int'(cur[p*4 +: 4])) % 10;
      repeat (ups) press(k, B_U);
      press(k, B_R);
    end
  endtask

  task automatic check(string nm, int k, logic [39:0] es, logic [4:0] ea,
                       logic [15:0] el, logic ew, logic elo);
    logic [39:0] s; logic [4:0] a; logic [15:0] l; logic w, lo;
    case (k)
      0:       begin s = 40'(seg0); a = att0; l = led0;      w = win0; lo = lose0; end
      1:       begin s = 40'(seg1); a = att1; l = 16'(led1); w = win1; lo = lose1; end
      default: begin s = 40'(seg2); a = att2; l = led2;      w = win2; lo = lose2; end
    endcase
    checks += 5;
    if (s !== es)  begin errors++; $display("FAIL %s seg_data got %h want %h", nm, s, es); end
    if (a !== ea)  begin errors++; $display("FAIL %s attempts got %0d want %0d", nm, a, ea); end
    if (l !== el)  begin errors++; $display("FAIL %s led got %h want %h", nm, l, el); end
    if (w !== ew)  begin errors++; $display("FAIL %s win got %b want %b", nm, w, ew); end
    if (lo !== elo) begin errors++; $display("FAIL %s lose got %b want %b", nm, lo, elo); end
  endtask

  initial begin
    reset = 1'b1;
    act   = 3'b111;
    for (int k = 0; k < 3; k++) btn[k] = 5'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) check($sformatf("reset%0d", k), k, '0, 5'd0, 16'd0, 1'b0, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // Default instance: duplicate answer, accepted answer, dup guess, scoring, win.
    add(0, 1, 0, 'h1123, 0, digs(4, 'h1123), 0, 0, 0, 0);
    add(0, 0, 0, 0, B_L, digs(4, 'h1123), 0, 0, 0, 0);
    add(0, 0, 0, 0, B_C, m4(4, C_HYPHEN, C_E, C_r, C_r), 0, 0, 0, 0);
    add(0, 0, 0, 0, B_C, digs(4, 'h1123), 0, 0, 0, 0);
    add(0, 1, 'h1123, 'h1234, 0, digs(4, 'h1234), 0, 0, 0, 0);
    add(0, 0, 0, 0, B_C, m4(4, C_g, C_o, C_g, C_o), 0, 0, 0, 0);
    add(0, 0, 0, 0, B_C, digs(4, 0), 0, 0, 0, 0);
    add(0, 1, 0, 'h5566, 0, digs(4, 'h5566), 0, 0, 0, 0);
    add(0, 0, 0, 0, B_C, m4(4, C_HYPHEN, C_E, C_r, C_r), 0, 0, 0, 0);
    add(0, 0, 0, 0, B_C, digs(4, 'h5566), 0, 0, 0, 0);
    add(0, 1, 'h5566, 'h4321, 0, digs(4, 'h4321), 0, 0, 0, 0);
    add(0, 0, 0, 0, B_C, m4(4, 5'd0, C_S, 5'd4, C_b), 1, 16'h0001, 0, 0);
    add(0, 0, 0, 0, B_C, digs(4, 'h4321), 1, 16'h0001, 0, 0);
    add(0, 1, 'h4321, 'h1243, 0, digs(4, 'h1243), 1, 16'h0001, 0, 0);
    add(0, 0, 0, 0, B_C, m4(4, 5'd2, C_S, 5'd2, C_b), 2, 16'h0003, 0, 0);
    add(0, 0, 0, 0, B_C, digs(4, 'h1243), 2, 16'h0003, 0, 0);
    add(0, 1, 'h1243, 'h1234, 0, digs(4, 'h1234), 2, 16'h0003, 0, 0);
    add(0, 0, 0, 0, B_C, m4(4, C_g, C_o, C_o, C_d), 3, 16'h0007, 1, 0);
    add(0, 0, 0, 0, B_C, '0, 0, 0, 0, 0);
    // Two-attempt instance: lose, then win on the last attempt.
    add(1, 1, 0, 'h1234, 0, digs(4, 'h1234), 0, 0, 0, 0);
    add(1, 0, 0, 0, B_C, m4(4, C_g, C_o, C_g, C_o), 0, 0, 0, 0);
    add(1, 0, 0, 0, B_C, digs(4, 0), 0, 0, 0, 0);
    add(1, 1, 0, 'h4321, 0, digs(4, 'h4321), 0, 0, 0, 0);
    add(1, 0, 0, 0, B_C, m4(4, 5'd0, C_S, 5'd4, C_b), 1, 16'h1, 0, 0);
    add(1, 0, 0, 0, B_C, digs(4, 'h4321), 1, 16'h1, 0, 0);
    add(1, 1, 'h4321, 'h1243, 0, digs(4, 'h1243), 1, 16'h1, 0, 0);
    add(1, 0, 0, 0, B_C, m4(4, C_L, C_o, C_S, C_E), 2, 16'h3, 0, 1);
    add(1, 0, 0, 0, B_C, '0, 0, 0, 0, 0);
    add(1, 1, 0, 'h1234, 0, digs(4, 'h1234), 0, 0, 0, 0);
    add(1, 0, 0, 0, B_C, m4(4, C_g, C_o, C_g, C_o), 0, 0, 0, 0);
    add(1, 0, 0, 0, B_C, digs(4, 0), 0, 0, 0, 0);
    add(1, 1, 0, 'h4321, 0, digs(4, 'h4321), 0, 0, 0, 0);
    add(1, 0, 0, 0, B_C, m4(4, 5'd0, C_S, 5'd4, C_b), 1, 16'h1, 0, 0);
    add(1, 0, 0, 0, B_C, digs(4, 'h4321), 1, 16'h1, 0, 0);
    add(1, 1, 'h4321, 'h1234, 0, digs(4, 'h1234), 1, 16'h1, 0, 0);
    add(1, 0, 0, 0, B_C, m4(4, C_g, C_o, C_o, C_d), 2, 16'h3, 1, 0);
    // Six-digit instance: wraps, cursor wrap, blank upper fields, up+confirm priority.
    add(2, 1, 0, 'h000009, 0, digs(6, 'h000009), 0, 0, 0, 0);
    add(2, 0, 0, 0, B_U, digs(6, 0), 0, 0, 0, 0);
    add(2, 0, 0, 0, B_D, digs(6, 'h000009), 0, 0, 0, 0);
    add(2, 0, 0, 0, B_U, digs(6, 0), 0, 0, 0, 0);
    add(2, 0, 0, 0, B_L, digs(6, 0), 0, 0, 0, 0);
    add(2, 0, 0, 0, B_U, digs(6, 'h100000), 0, 0, 0, 0);
    add(2, 0, 0, 0, B_L | B_R, digs(6, 'h100000), 0, 0, 0, 0);
    add(2, 0, 0, 0, B_R, digs(6, 'h100000), 0, 0, 0, 0);
    add(2, 1, 'h100000, 'h123456, 0, digs(6, 'h123456), 0, 0, 0, 0);
    add(2, 0, 0, 0, B_C, m4(6, C_g, C_o, C_g, C_o), 0, 0, 0, 0);
    add(2, 0, 0, 0, B_C, digs(6, 0), 0, 0, 0, 0);
    add(2, 1, 0, 'h654321, 0, digs(6, 'h654321), 0, 0, 0, 0);
    add(2, 0, 0, 0, B_U | B_C, m4(6, 5'd0, C_S, 5'd6, C_b), 1, 16'h1, 0, 0);
    add(2, 0, 0, 0, B_C, digs(6, 'h654321), 1, 16'h1, 0, 0);

    for (int i = 0; i < steps.size(); i++) begin
      if (steps[i].ent) enter(steps[i].k, (steps[i].k == 2) ? 6 : 4, steps[i].cur, steps[i].tgt);
      else              press(steps[i].k, steps[i].mask);
      check($sformatf("step%0d", i), steps[i].k, steps[i].seg, steps[i].att,
            steps[i].led, steps[i].w, steps[i].l);
    end

    // Mode deselected for one cycle mid-guess.
    act[2] = 1'b0;
    @(negedge clk);
    act[2] = 1'b1;
    check("active_drop", 2, '0, 5'd0, 16'd0, 1'b0, 1'b0);
    @(negedge clk);
    press(2, B_U);
    check("after_drop", 2, digs(6, 'h000001), 5'd0, 16'd0, 1'b0, 1'b0);

    // A held button acts once.
    btn[2] = B_U;
    repeat (5) @(negedge clk);
    btn[2] = 5'b0;
    @(negedge clk);
    check("held_up", 2, digs(6, 'h000002), 5'd0, 16'd0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/number_baseball_core.md
# number_baseball_core

Parametrised number-baseball game engine: a setter enters a secret of NUM_DIGITS distinct digits, a guesser gets up to MAX_ATTEMPTS guesses, and the block scores each guess as strikes/balls. It sits under the top-level mode multiplexer beside the other game modes. It takes debounced button levels and drives the shared 5-bit-per-character seven-segment bus and the LED bar. It replaces the fixed 4-digit/16-attempt mode and adds an error-acknowledge state, restart from end states, and status outputs.

## Interface
Parameters:
- NUM_DIGITS, 4: secret/guess length; legal range 4..8.
- DIGIT_MAX, 9: largest digit value; requires DIGIT_MAX+1 >= NUM_DIGITS and DIGIT_MAX <= 9.
- MAX_ATTEMPTS, 16: guesses allowed; legal range 1..16.
- BLINK_DIV, 50_000_000: clk cycles per blink half-period.

Ports:
- clk  in  1  system clock; the block uses this single clock.
- reset  in  1  synchronous, active-high reset.
- active  in  1  mode selected; low acts as a synchronous reset of all game state.
- btn_up / btn_down / btn_left / btn_right / btn_confirm  in  1 each  debounced levels; edges are detected internally.
- led  out  MAX_ATTEMPTS  thermometer of used attempts.
- seg_data  out  5*NUM_DIGITS  character codes; the most significant field is the leftmost digit.
- attempts  out  5  valid guesses taken.
- win  out  1  high in WIN.
- lose  out  1  high in LOSE.

## Operation
- States: IDLE, INPUT_ANSWER, ANSWER_CHECK, INPUT_GUESS, GUESS_ERR, SHOW_RESULT, WIN, LOSE.
- IDLE goes to INPUT_ANSWER on the next cycle when active is high.
- Button edges: btn_x high and btn_x_prev low. Only one action is taken per cycle, with priority confirm > up > down > left/right.
- Left and right together: no cursor move.
- Digit editing: up increments the cursor digit and wraps DIGIT_MAX→0; down decrements and wraps 0→DIGIT_MAX.
- Cursor movement: right moves to cursor+1, left to cursor−1, both modulo NUM_DIGITS. Cursor 0 is the rightmost digit.
- The cursor is cleared to 0 on every entry to INPUT_ANSWER or INPUT_GUESS.
- INPUT_ANSWER: confirm goes to ANSWER_CHECK.
- ANSWER_CHECK: displays "-Err" if any pair of digits is equal, otherwise "gogo".
  - Confirm goes back to INPUT_ANSWER with the answer digits kept (if duplicates), or to INPUT_GUESS.
- INPUT_GUESS, confirm:
  - Duplicate guess: go to GUESS_ERR; the attempt is not counted.
  - Otherwise register strike/ball, increment attempts, and set led[attempts].
  - Then: exact match goes to WIN (WIN has priority even on the last attempt). New attempts == MAX_ATTEMPTS goes to LOSE. Anything else goes to SHOW_RESULT.
- GUESS_ERR: displays "-Err"; confirm returns to INPUT_GUESS with guess digits kept.
- SHOW_RESULT: displays {strike, S, ball, b}; confirm goes to INPUT_GUESS with guess digits kept.
- WIN displays "good"; LOSE displays "LoSE". Confirm in either returns to IDLE and clears all game state.
- Strike/ball arithmetic:
  - strike = count of i with guess[i]==answer[i].
  - ball = count of (i≠j) pairs with guess[i]==answer[j].
  - Both are $clog2(NUM_DIGITS+1) bits wide and are computed combinationally from the registered digits.
- Four-character messages are right-aligned; the upper NUM_DIGITS−4 fields are C_BLANK.
- Input display: each digit is shown as {1'b0,digit}. The cursor digit shows C_BLANK while blink_phase is 1.
- Blink counter counts 0..BLINK_DIV−1 and toggles blink_phase at the wrap. It free-runs and is cleared only by reset.

## Timing
- All outputs are registered.
- Reset values: led=0, seg_data=all C_0 (zero), attempts=0, win=0, lose=0. State=IDLE, cursor=0, all digits 0.
- Button edge on cycle n: the state/digit update happens at the end of cycle n. seg_data reflects it at the end of cycle n+1.
- win/lose assert at the end of the cycle after the state enters WIN/LOSE.
- reset or active low mid-game takes effect at the next clk edge. It overrides any simultaneous button edge.
- A button held high produces one action only.

## Configuration
- BASEBALL_ANSWER_MASK_EN defined: in INPUT_ANSWER every non-cursor digit displays C_HYPHEN, so the secret stays hidden from the guesser.
- BASEBALL_ANSWER_MASK_EN undefined: all answer digits display normally.
- The macro has no effect on any other state.

## Structure
- Shared package baseball_pkg holds:
  - the state enum;
  - character codes C_BLANK=31, C_HYPHEN=10, C_E=11, C_r=12, C_L=13, C_o=17, C_b=18, C_d=19, C_S=5, C_g=9;
  - the four-character message constants.
- One sub-module, baseball_scorer: purely combinational. Inputs are the guess and answer vectors; outputs are strike, ball, dup_guess and exact.
- Duplicate check on the answer reuses a second baseball_scorer instance, or a function in the package.

## Test plan
- Default params, answer 1234 accepted ("gogo"), guess 4321 → SHOW_RESULT shows {0,S,4,b}, attempts=1, led=0x0001.
- Answer 1123 → ANSWER_CHECK shows {C_HYPHEN,C_E,C_r,C_r}; confirm → INPUT_ANSWER with digits 1123 retained and cursor 0.
- Guess 5566 → GUESS_ERR, attempts unchanged; confirm → INPUT_GUESS.
- MAX_ATTEMPTS=2: two wrong guesses → LOSE, lose=1, led=0b11. Repeat with the second guess correct → WIN (not LOSE).
- NUM_DIGITS=6: result shows blanks in the upper two fields. Up from 9 wraps to 0; left at cursor 0 moves to 5. Up+confirm in the same cycle does only the confirm.
- active dropped for one cycle mid-guess → all outputs return to reset values on the next cycle, then IDLE→INPUT_ANSWER.
